axi2apb_ctrl_mslv: RTL and testbench

Parametrised APB transfer controller for the AXI-to-APB bridge. It takes one decoded command at a time from the command queue and drives a full APB SETUP/ACCESS sequence.
- Decodes the slave index from the command address and fans out to NUM_SLAVES PSEL lines.
- Muxes per-slave PREADY/PSLVERR back into the controller.
- Adds an ACCESS-phase timeout and a response handshake towards the AXI B/R formatting logic.

---
 rtl/axi2apb_ctrl_mslv_pkg.sv | 22 ++
 rtl/axi2apb_ctrl_mslv_if.sv | 38 +++
 rtl/axi2apb_timeout_cnt.sv | 31 +++
 rtl/axi2apb_ctrl_mslv.sv | 140 ++++++++++++++
 tb/tb_axi2apb_ctrl_mslv.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi2apb_ctrl_mslv_pkg.sv
// Shared types and constants for the AXI-to-APB transfer controller.
// Pure declarations: no latency, no flow control.
// Imported by the controller, its timeout counter and the bench.
package axi2apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Width of the slave-index field; a single slave still needs one bit.
    function automatic int sel_width(input int num_slaves);
        return (num_slaves <= 2) ? 1 : $clog2(num_slaves);
    endfunction

endpackage

// File: rtl/axi2apb_ctrl_mslv_if.sv
// Command, write-data, APB and response signals of the transfer controller.
// No logic, no latency.
// master = controller view, slave = command queue / APB slaves / response side.
interface axi2apb_ctrl_mslv_if #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_read;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  wvalid;
    logic                  w_pop;
    logic [NUM_SLAVES-1:0] psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [NUM_SLAVES-1:0] pready;
    logic [NUM_SLAVES-1:0] pslverr;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [1:0]            resp;
    logic                  resp_timeout;
    logic                  resp_read;

    modport master (
        input  cmd_valid, cmd_read, cmd_addr, wvalid, pready, pslverr, resp_ready,
        output cmd_ready, w_pop, psel, penable, pwrite, paddr,
        output resp_valid, resp, resp_timeout, resp_read
    );

    modport slave (
        output cmd_valid, cmd_read, cmd_addr, wvalid, pready, pslverr, resp_ready,
        input  cmd_ready, w_pop, psel, penable, pwrite, paddr,
        input  resp_valid, resp, resp_timeout, resp_read
    );

endinterface

// File: rtl/axi2apb_timeout_cnt.sv
// ACCESS-phase wait counter; expired fires combinationally in the limit cycle.
// Latency: expired is same-cycle on en; count updates on the next edge.
// No backpressure; saturates at TIMEOUT_CYCLES, TIMEOUT_CYCLES = 0 never expires.
module axi2apb_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int LIM = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    localparam logic [CW-1:0] CNT_LIMIT = CW'(LIM);
    localparam logic [CW-1:0] CNT_SAT   = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_SAT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && en && (cnt == CNT_LIMIT);

endmodule

// File: rtl/axi2apb_ctrl_mslv.sv
// APB transfer controller: one command -> SETUP/ACCESS on the decoded slave -> response.
// Latency: accept at cycle 0, SETUP 1, ACCESS 2+, resp_valid one cycle after ACCESS ends.
// Backpressure: no command accepted until the response handshake; write waits for wvalid.
module axi2apb_ctrl_mslv
    import axi2apb_pkg::*;
#(
    parameter int NUM_SLAVES     = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int SEL_LSB        = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rstn,
    axi2apb_ctrl_mslv_if.master bus
);
    localparam int SEL_W = sel_width(NUM_SLAVES);

    apb_state_e state, state_nxt;

    logic [NUM_SLAVES-1:0] psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [1:0]            resp_q;
    logic                  resp_to_q;
    logic                  resp_read_q;

    logic [SEL_W-1:0]      idx;
    logic                  idx_hit;
    logic [NUM_SLAVES-1:0] sel_dec;
    logic                  start;
    logic                  slv_rdy;
    logic                  slv_err;
    logic                  cnt_en;
    logic                  cnt_clr;
    logic                  expired;
    logic                  access_done;

    assign idx     = bus.cmd_addr[SEL_LSB +: SEL_W];
    assign idx_hit = int'(idx) < NUM_SLAVES;

    always_comb begin
        sel_dec = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_dec[i] = (int'(idx) == i);
        end
    end

    assign start = (state == IDLE) && bus.cmd_valid && (bus.cmd_read || bus.wvalid);

    // psel is one-hot, so masking picks the selected slave's lines only.
    assign slv_rdy = |(bus.pready  & psel_q);
    assign slv_err = |(bus.pslverr & psel_q);

    assign cnt_en      = (state == ACCESS) && !slv_rdy;
    assign cnt_clr     = (state == RESP) && bus.resp_ready;
    assign access_done = (state == ACCESS) && (slv_rdy || expired);

    axi2apb_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.cmd_ready = 1'b0;
        bus.w_pop     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    bus.cmd_ready = 1'b1;
                    bus.w_pop     = !bus.cmd_read;
                    state_nxt     = idx_hit ? SETUP : RESP;
                end
            end
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (access_done) state_nxt = RESP;
            RESP:    if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            resp_q      <= RESP_OKAY;
            resp_to_q   <= 1'b0;
            resp_read_q <= 1'b0;
        end else begin
            if (start) begin
                resp_read_q <= bus.cmd_read;
                resp_to_q   <= 1'b0;
                if (idx_hit) begin
                    psel_q   <= sel_dec;
                    paddr_q  <= bus.cmd_addr;
                    pwrite_q <= !bus.cmd_read;
                end else begin
                    resp_q <= RESP_DECERR;
                end
            end
            if (state == SETUP) begin
                penable_q <= 1'b1;
            end
            // A ready slave in the limit cycle takes precedence over the abort.
            if (access_done) begin
                psel_q    <= '0;
                penable_q <= 1'b0;
                pwrite_q  <= 1'b0;
                resp_q    <= (slv_rdy && !slv_err) ? RESP_OKAY : RESP_SLVERR;
                resp_to_q <= !slv_rdy;
            end
        end
    end

    assign bus.psel         = psel_q;
    assign bus.penable      = penable_q;
    assign bus.pwrite       = pwrite_q;
    assign bus.paddr        = paddr_q;
    assign bus.resp_valid   = (state == RESP);
    assign bus.resp         = resp_q;
    assign bus.resp_timeout = resp_to_q;
    assign bus.resp_read    = resp_read_q;

endmodule

// File: tb/tb_axi2apb_ctrl_mslv.sv
// Bench for axi2apb_ctrl_mslv with 3 slaves and an 8-cycle ACCESS timeout.
// Directed scenarios plus randomized transfers against a transaction-level model.
module tb_axi2apb_ctrl_mslv;
    import axi2apb_pkg::*;

    localparam int NS = 3;
    localparam int AW = 32;
    localparam int TO = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    axi2apb_ctrl_mslv_if #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW)) bus ();

    axi2apb_ctrl_mslv #(
        .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .SEL_LSB(12), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus.master)
    );

    // Observations of one transfer, relative to the cycle the command was offered.
    int          o_acc_k, o_resp_k, o_setup, o_en, o_bad, o_unstable, o_extra, o_rv_cycles;
    logic        o_wpop, o_to, o_rread;
    logic [NS-1:0] o_psel;
    logic [1:0]  o_resp;

    // Expected values from the transaction-level model.
    int          e_acc_k, e_resp_k, e_setup, e_en;
    logic        e_wpop, e_to;
    logic [NS-1:0] e_psel;
    logic [1:0]  e_resp;

    task automatic idle_inputs();
        bus.cmd_valid  = 1'b0;
        bus.cmd_read   = 1'b0;
        bus.cmd_addr   = '0;
        bus.wvalid     = 1'b0;
        bus.pready     = '0;
        bus.pslverr    = '0;
        bus.resp_ready = 1'b0;
    endtask

    // Offers one command until its response handshake; the addressed slave raises
    // pready on ACCESS cycle number pdly (0-based). Called at a falling edge.
    task automatic run_xfer(input bit rd, input logic [AW-1:0] addr, input int wdly,
                            input int pdly, input bit err, input int rdly);
        int  k = 0;
        int  acc_cnt = 0;
        int  rv_cnt = 0;
        bit  done = 0;
        logic [NS-1:0] sel_now;
        o_acc_k = -1; o_resp_k = -1; o_setup = 0; o_en = 0; o_bad = 0;
        o_unstable = 0; o_extra = 0; o_rv_cycles = 0; o_wpop = 0; o_psel = '0;
        o_resp = '0; o_to = 0; o_rread = 0;
        while (!done && k < 300) begin
            sel_now        = bus.psel;
            bus.cmd_valid  = 1'b1;
            bus.cmd_read   = rd;
            bus.cmd_addr   = addr;
            bus.wvalid     = rd ? 1'($urandom_range(0, 1)) : (k >= wdly);
            bus.pready     = (NS'($urandom) & ~sel_now) |
                             (sel_now & {NS{bus.penable && acc_cnt == pdly}});
            bus.pslverr    = (NS'($urandom) & ~sel_now) | (sel_now & {NS{err}});
            bus.resp_ready = bus.resp_valid && (rv_cnt >= rdly);
            #1;
            if (bus.cmd_ready) begin
                if (o_acc_k < 0) begin o_acc_k = k; o_wpop = bus.w_pop; end
                else o_extra++;
            end else if (bus.w_pop) o_extra++;
            if (bus.psel != '0) begin
                if ($countones(bus.psel) != 1) o_bad++;
                if (o_psel == '0) o_psel = bus.psel;
                else if (bus.psel != o_psel) o_bad++;
                if (bus.paddr !== addr || bus.pwrite !== !rd) o_bad++;
                if (bus.penable) begin o_en++; acc_cnt++; end
                else o_setup++;
            end else if (bus.penable) o_bad++;
            if (bus.resp_valid) begin
                if (o_resp_k < 0) begin
                    o_resp_k = k; o_resp = bus.resp; o_to = bus.resp_timeout;
                    o_rread = bus.resp_read;
                end else if (bus.resp !== o_resp || bus.resp_timeout !== o_to ||
                             bus.resp_read !== o_rread) o_unstable++;
                o_rv_cycles++;
                rv_cnt++;
                if (bus.resp_ready) done = 1;
            end
            @(negedge clk);
            k++;
        end
        idle_inputs();
    endtask

    // Expected outcome of one transfer from the address map and slave behaviour.
    task automatic model_xfer(input bit rd, input logic [AW-1:0] addr, input int wdly,
                              input int pdly, input bit err);
        int idx = int'((addr >> 12) & 32'h3);
        e_acc_k = rd ? 0 : wdly;
        e_wpop  = !rd;
        if (idx >= NS) begin
            e_psel = '0; e_setup = 0; e_en = 0; e_resp = RESP_DECERR; e_to = 0;
            e_resp_k = e_acc_k + 1;
        end else begin
            e_psel  = NS'(1 << idx);
            e_setup = 1;
            e_en    = (pdly < TO) ? pdly + 1 : TO;
            e_resp  = (pdly < TO) ? (err ? RESP_SLVERR : RESP_OKAY) : RESP_SLVERR;
            e_to    = (pdly >= TO);
            e_resp_k = e_acc_k + 2 + e_en;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.psel !== '0 || bus.penable !== 1'b0 || bus.pwrite !== 1'b0) begin
            errors++; $display("FAIL reset_apb psel=%b penable=%b pwrite=%b want 0", bus.psel, bus.penable, bus.pwrite); end
        checks++; if (bus.paddr !== '0) begin
            errors++; $display("FAIL reset_paddr got %h want 0", bus.paddr); end
        checks++; if (bus.resp_valid !== 1'b0 || bus.resp !== 2'b00) begin
            errors++; $display("FAIL reset_resp valid=%b resp=%b want 0/00", bus.resp_valid, bus.resp); end
        checks++; if (bus.resp_timeout !== 1'b0 || bus.resp_read !== 1'b0 || bus.cmd_ready !== 1'b0) begin
            errors++; $display("FAIL reset_misc to=%b rd=%b cmd_ready=%b want 0", bus.resp_timeout, bus.resp_read, bus.cmd_ready); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_slave2();
        run_xfer(1, 32'h0000_2000, 0, 0, 0, 0);
        checks++; if (o_acc_k !== 0 || o_wpop !== 1'b0) begin
            errors++; $display("FAIL rd2_accept cycle=%0d w_pop=%b want 0/0", o_acc_k, o_wpop); end
        checks++; if (o_psel !== 3'b100 || o_setup !== 1 || o_en !== 1) begin
            errors++; $display("FAIL rd2_apb psel=%b setup=%0d access=%0d want 100/1/1", o_psel, o_setup, o_en); end
        checks++; if (o_resp_k !== 3 || o_resp !== 2'b00 || o_rread !== 1'b1) begin
            errors++; $display("FAIL rd2_resp cycle=%0d resp=%b rd=%b want 3/00/1", o_resp_k, o_resp, o_rread); end
    endtask

    task automatic test_write_late();
        run_xfer(0, 32'h0000_1abc, 3, 0, 0, 0);
        checks++; if (o_acc_k !== 3 || o_wpop !== 1'b1 || o_extra !== 0) begin
            errors++; $display("FAIL wr_late_accept cycle=%0d w_pop=%b extra=%0d want 3/1/0", o_acc_k, o_wpop, o_extra); end
        checks++; if (o_psel !== 3'b010 || o_bad !== 0) begin
            errors++; $display("FAIL wr_late_bus psel=%b bad=%0d want 010/0", o_psel, o_bad); end
        checks++; if (o_resp_k !== 6 || o_resp !== 2'b00 || o_rread !== 1'b0) begin
            errors++; $display("FAIL wr_late_resp cycle=%0d resp=%b rd=%b want 6/00/0", o_resp_k, o_resp, o_rread); end
    endtask

    // Slave 1 answers on its fifth ACCESS cycle with an error.
    task automatic test_wait_slverr();
        run_xfer(1, 32'h0000_1000, 0, 4, 1, 0);
        checks++; if (o_en !== 5 || o_bad !== 0) begin
            errors++; $display("FAIL wait_err_access cycles=%0d bad=%0d want 5/0", o_en, o_bad); end
        checks++; if (o_resp !== RESP_SLVERR || o_to !== 1'b0 || o_resp_k !== 7) begin
            errors++; $display("FAIL wait_err_resp resp=%b to=%b cycle=%0d want 10/0/7", o_resp, o_to, o_resp_k); end
    endtask

    // Abort after the limit, then a ready in the limit cycle; the second also shows the counter cleared.
    task automatic test_timeout();
        run_xfer(0, 32'h0000_0040, 0, 1000, 0, 1);
        checks++; if (o_en !== TO || o_resp !== RESP_SLVERR || o_to !== 1'b1) begin
            errors++; $display("FAIL timeout_abort access=%0d resp=%b to=%b want 8/10/1", o_en, o_resp, o_to); end
        checks++; if (o_resp_k !== 10) begin
            errors++; $display("FAIL timeout_abort_cycle got %0d want 10", o_resp_k); end
        run_xfer(1, 32'h0000_0040, 0, TO - 1, 0, 0);
        checks++; if (o_en !== TO || o_resp !== RESP_OKAY || o_to !== 1'b0) begin
            errors++; $display("FAIL timeout_race access=%0d resp=%b to=%b want 8/00/0", o_en, o_resp, o_to); end
    endtask

    task automatic test_decerr();
        run_xfer(1, 32'h0000_3004, 0, 0, 0, 4);
        checks++; if (o_psel !== 3'b000 || o_setup !== 0 || o_en !== 0) begin
            errors++; $display("FAIL decerr_apb psel=%b setup=%0d access=%0d want 000/0/0", o_psel, o_setup, o_en); end
        checks++; if (o_resp_k !== 1 || o_resp !== RESP_DECERR || o_to !== 1'b0) begin
            errors++; $display("FAIL decerr_resp cycle=%0d resp=%b to=%b want 1/11/0", o_resp_k, o_resp, o_to); end
        checks++; if (o_rv_cycles !== 5 || o_unstable !== 0 || o_extra !== 0) begin
            errors++; $display("FAIL decerr_hold valid_cycles=%0d unstable=%0d extra_ready=%0d want 5/0/0", o_rv_cycles, o_unstable, o_extra); end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        int k = 0;
        bus.cmd_valid = 1'b1; bus.cmd_read = 1'b1; bus.cmd_addr = 32'h0000_2000;
        bus.pready = '0; bus.pslverr = '0;
        while (!seen && k < 20) begin
            #1;
            if (bus.penable) seen = 1;
            else begin @(negedge clk); k++; end
            bus.cmd_valid = 1'b0;
        end
        checks++; if (!seen) begin
            errors++; $display("FAIL rst_mid_reach_access penable=%b want 1", bus.penable); end
        rstn = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (bus.psel !== '0 || bus.penable !== 1'b0 || bus.resp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_drop psel=%b penable=%b resp_valid=%b want 0", bus.psel, bus.penable, bus.resp_valid); end
        rstn = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            bus.pready = NS'($urandom);
            #1;
            if (bus.resp_valid || bus.psel != '0) seen = 1;
        end
        bus.pready = '0;
        @(negedge clk);
        checks++; if (seen) begin
            errors++; $display("FAIL rst_mid_quiet activity after reset got 1 want 0"); end
        run_xfer(1, 32'h0000_2010, 0, 0, 0, 0);
        checks++; if (o_resp_k !== 3 || o_resp !== RESP_OKAY || o_psel !== 3'b100) begin
            errors++; $display("FAIL rst_mid_after cycle=%0d resp=%b psel=%b want 3/00/100", o_resp_k, o_resp, o_psel); end
    endtask

    task automatic test_back_to_back();
        run_xfer(0, 32'h0000_0008, 0, 0, 0, 0);
        run_xfer(1, 32'h0000_200c, 0, 0, 0, 0);
        checks++; if (o_acc_k !== 0 || o_resp_k !== 3 || o_psel !== 3'b100) begin
            errors++; $display("FAIL b2b_second accept=%0d resp_cycle=%0d psel=%b want 0/3/100", o_acc_k, o_resp_k, o_psel); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            bit rd = 1'($urandom_range(0, 1));
            bit err = 1'($urandom_range(0, 1));
            int idx = $urandom_range(0, 3);
            int wdly = $urandom_range(0, 3);
            int pdly = $urandom_range(0, 10);
            int rdly = $urandom_range(0, 3);
            logic [AW-1:0] addr = ($urandom & ~32'h3000) | AW'(idx << 12);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            model_xfer(rd, addr, wdly, pdly, err);
            run_xfer(rd, addr, wdly, pdly, err, rdly);
            checks++; if (o_acc_k !== e_acc_k || o_wpop !== e_wpop) begin
                errors++; $display("FAIL rnd%0d_accept cycle=%0d w_pop=%b want %0d/%b", n, o_acc_k, o_wpop, e_acc_k, e_wpop); end
            checks++; if (o_psel !== e_psel) begin
                errors++; $display("FAIL rnd%0d_psel got %b want %b", n, o_psel, e_psel); end
            checks++; if (o_setup !== e_setup || o_en !== e_en) begin
                errors++; $display("FAIL rnd%0d_phases setup=%0d access=%0d want %0d/%0d", n, o_setup, o_en, e_setup, e_en); end
            checks++; if (o_resp_k !== e_resp_k) begin
                errors++; $display("FAIL rnd%0d_resp_cycle got %0d want %0d", n, o_resp_k, e_resp_k); end
            checks++; if (o_resp !== e_resp || o_to !== e_to || o_rread !== rd) begin
                errors++; $display("FAIL rnd%0d_resp resp=%b to=%b rd=%b want %b/%b/%b", n, o_resp, o_to, o_rread, e_resp, e_to, rd); end
            checks++; if (o_rv_cycles !== rdly + 1 || o_unstable !== 0) begin
                errors++; $display("FAIL rnd%0d_hold valid_cycles=%0d unstable=%0d want %0d/0", n, o_rv_cycles, o_unstable, rdly + 1); end
            checks++; if (o_bad !== 0 || o_extra !== 0) begin
                errors++; $display("FAIL rnd%0d_protocol bad=%0d extra=%0d want 0/0", n, o_bad, o_extra); end
        end
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_read_slave2();
        test_write_late();
        test_wait_slverr();
        test_timeout();
        test_decerr();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
